control_unit: RTL and testbench

Hardwired Moore control sequencer for the Mini SRC `DataPath`. It replaces the hand-driven control signals with a fetch/decode/execute state machine. Outputs drive the datapath's enable, out and `Read` strobes and `alu_control`. Inputs are the latched instruction register contents and a memory-ready handshake. The block covers the register-register ALU, unary, multiply/divide, nop and halt instruction classes.

---
 rtl/control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_control_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired Moore fetch/decode/execute sequencer for the Mini SRC datapath.
// Outputs are decoded from the current state and the instruction register only.
module control_unit #(
    parameter logic [4:0] PC_INC_OP = 5'b11111
) (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_run,
    input  logic [31:0] i_ir,
    input  logic        i_mem_rdy,
    output logic [4:0]  o_alu_control,
    output logic [15:0] o_r_en,
    output logic [15:0] o_r_out,
    output logic        o_mar_en,
    output logic        o_mdr_en,
    output logic        o_read,
    output logic        o_mdr_out,
    output logic        o_ir_en,
    output logic        o_p_en,
    output logic        o_p_out,
    output logic        o_y_en,
    output logic        o_zlo_en,
    output logic        o_zhi_en,
    output logic        o_zlo_out,
    output logic        o_zhi_out,
    output logic        o_hi_en,
    output logic        o_lo_en,
    output logic        o_halt,
    output logic        o_illegal
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T1W  = 4'd3;
    localparam logic [3:0] S_T2   = 4'd4;
    localparam logic [3:0] S_T3   = 4'd5;
    localparam logic [3:0] S_T4   = 4'd6;
    localparam logic [3:0] S_T5   = 4'd7;
    localparam logic [3:0] S_T6   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    logic [3:0]  r_state;
    logic [3:0]  w_state_next;
    logic        r_illegal;

    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic [15:0] w_ra_oh;
    logic [15:0] w_rb_oh;
    logic [15:0] w_rc_oh;
    logic        w_is_alu3;
    logic        w_is_un;
    logic        w_is_md;
    logic        w_is_nop;
    logic        w_is_hlt;
    logic        w_is_legal;
    logic        w_unused_ir_bits;

    assign w_opcode = i_ir[31:27];
    assign w_ra     = i_ir[26:23];
    assign w_rb     = i_ir[22:19];
    assign w_rc     = i_ir[18:15];
    assign w_unused_ir_bits = ^i_ir[14:0];

    assign w_is_alu3  = (w_opcode <= 5'h08);
    assign w_is_un    = (w_opcode == 5'h11) || (w_opcode == 5'h12);
    assign w_is_md    = (w_opcode == 5'h0F) || (w_opcode == 5'h10);
    assign w_is_nop   = (w_opcode == 5'h1B);
    assign w_is_hlt   = (w_opcode == 5'h1C);
    assign w_is_legal = w_is_alu3 | w_is_un | w_is_md | w_is_nop | w_is_hlt;

    // Register-field decoders: each field selects exactly one of R0..R15.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg_decode
            assign w_ra_oh[gi] = (w_ra == 4'(gi));
            assign w_rb_oh[gi] = (w_rb == 4'(gi));
            assign w_rc_oh[gi] = (w_rc == 4'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: w_state_next = i_run ? S_T0 : S_IDLE;
            S_T0:   w_state_next = S_T1;
            S_T1:   w_state_next = i_mem_rdy ? S_T2 : S_T1W;
            S_T1W:  w_state_next = i_mem_rdy ? S_T2 : S_T1W;
            S_T2:   w_state_next = S_T3;
            S_T3: begin
                if (w_is_alu3 || w_is_un || w_is_md)
                    w_state_next = S_T4;
                else if (w_is_nop)
                    w_state_next = S_T0;
                else
                    w_state_next = S_HALT;
            end
            S_T4:   w_state_next = (w_is_alu3 || w_is_md) ? S_T5 : S_T0;
            S_T5:   w_state_next = w_is_md ? S_T6 : S_T0;
            S_T6:   w_state_next = S_T0;
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The illegal flag is latched on entry to HALT so it no longer tracks ir.
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_T3 && !w_is_legal)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        o_alu_control = 5'd0;
        o_r_en        = 16'd0;
        o_r_out       = 16'd0;
        o_mar_en      = 1'b0;
        o_mdr_en      = 1'b0;
        o_read        = 1'b0;
        o_mdr_out     = 1'b0;
        o_ir_en       = 1'b0;
        o_p_en        = 1'b0;
        o_p_out       = 1'b0;
        o_y_en        = 1'b0;
        o_zlo_en      = 1'b0;
        o_zhi_en      = 1'b0;
        o_zlo_out     = 1'b0;
        o_zhi_out     = 1'b0;
        o_hi_en       = 1'b0;
        o_lo_en       = 1'b0;
        o_halt        = 1'b0;
        o_illegal     = 1'b0;
        case (r_state)
            S_T0: begin
                o_p_out       = 1'b1;
                o_mar_en      = 1'b1;
                o_zlo_en      = 1'b1;
                o_alu_control = PC_INC_OP;
            end
            S_T1: begin
                o_zlo_out = 1'b1;
                o_p_en    = 1'b1;
                o_read    = 1'b1;
                o_mdr_en  = 1'b1;
            end
            S_T1W: begin
                o_read   = 1'b1;
                o_mdr_en = 1'b1;
            end
            S_T2: begin
                o_mdr_out = 1'b1;
                o_ir_en   = 1'b1;
            end
            S_T3: begin
                if (w_is_alu3) begin
                    o_r_out = w_rb_oh;
                    o_y_en  = 1'b1;
                end else if (w_is_un) begin
                    o_r_out       = w_rb_oh;
                    o_zlo_en      = 1'b1;
                    o_alu_control = w_opcode;
                end else if (w_is_md) begin
                    o_r_out = w_ra_oh;
                    o_y_en  = 1'b1;
                end
            end
            S_T4: begin
                if (w_is_alu3) begin
                    o_r_out       = w_rc_oh;
                    o_zlo_en      = 1'b1;
                    o_alu_control = w_opcode;
                end else if (w_is_un) begin
                    o_zlo_out = 1'b1;
                    o_r_en    = w_ra_oh;
                end else if (w_is_md) begin
                    o_r_out       = w_rb_oh;
                    o_zhi_en      = 1'b1;
                    o_zlo_en      = 1'b1;
                    o_alu_control = w_opcode;
                end
            end
            S_T5: begin
                if (w_is_alu3) begin
                    o_zlo_out = 1'b1;
                    o_r_en    = w_ra_oh;
                end else if (w_is_md) begin
                    o_zlo_out = 1'b1;
                    o_lo_en   = 1'b1;
                end
            end
            S_T6: begin
                o_zhi_out = 1'b1;
                o_hi_en   = 1'b1;
            end
            S_HALT: begin
                o_halt    = 1'b1;
                o_illegal = r_illegal;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit: a per-cycle expected
// output trace is built from the instruction-class timing tables.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        mem_rdy = 1'b0;

    logic [4:0]  alu_control;
    logic [15:0] r_en, r_out;
    logic        mar_en, mdr_en, rd, mdr_out, ir_en, p_en, p_out, y_en;
    logic        zlo_en, zhi_en, zlo_out, zhi_out, hi_en, lo_en, halt, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit #(.PC_INC_OP(5'b11111)) dut (
        .i_clk(clk), .i_clr(clr), .i_run(run), .i_ir(ir), .i_mem_rdy(mem_rdy),
        .o_alu_control(alu_control), .o_r_en(r_en), .o_r_out(r_out),
        .o_mar_en(mar_en), .o_mdr_en(mdr_en), .o_read(rd), .o_mdr_out(mdr_out),
        .o_ir_en(ir_en), .o_p_en(p_en), .o_p_out(p_out), .o_y_en(y_en),
        .o_zlo_en(zlo_en), .o_zhi_en(zhi_en), .o_zlo_out(zlo_out), .o_zhi_out(zhi_out),
        .o_hi_en(hi_en), .o_lo_en(lo_en), .o_halt(halt), .o_illegal(illegal)
    );

    always #5 clk = ~clk;

    // Strobe masks in the order they are packed into the observed vector.
    localparam logic [13:0] M_MAR    = 14'h2000;
    localparam logic [13:0] M_MDREN  = 14'h1000;
    localparam logic [13:0] M_READ   = 14'h0800;
    localparam logic [13:0] M_MDROUT = 14'h0400;
    localparam logic [13:0] M_IREN   = 14'h0200;
    localparam logic [13:0] M_PEN    = 14'h0100;
    localparam logic [13:0] M_POUT   = 14'h0080;
    localparam logic [13:0] M_YEN    = 14'h0040;
    localparam logic [13:0] M_ZLOEN  = 14'h0020;
    localparam logic [13:0] M_ZHIEN  = 14'h0010;
    localparam logic [13:0] M_ZLOOUT = 14'h0008;
    localparam logic [13:0] M_ZHIOUT = 14'h0004;
    localparam logic [13:0] M_HIEN   = 14'h0002;
    localparam logic [13:0] M_LOEN   = 14'h0001;

    logic [52:0] obs;
    assign obs = {alu_control, r_en, r_out, mar_en, mdr_en, rd, mdr_out, ir_en, p_en,
                  p_out, y_en, zlo_en, zhi_en, zlo_out, zhi_out, hi_en, lo_en, halt, illegal};

    logic [52:0] q_exp[$];
    string       q_name[$];
    logic        q_rdy[$];
    logic        q_real[$];

    function automatic logic [52:0] mk(input logic [4:0] alu, input logic [15:0] ren,
                                       input logic [15:0] rout, input logic [13:0] st,
                                       input logic h, input logic il);
        return {alu, ren, rout, st, h, il};
    endfunction

    function automatic logic [15:0] sel(input logic [3:0] r);
        return 16'(1) << r;
    endfunction

    task automatic push(input logic [52:0] v, input string nm, input logic rdy, input logic real_ir);
        q_exp.push_back(v);
        q_name.push_back(nm);
        q_rdy.push_back(rdy);
        q_real.push_back(real_ir);
    endtask

    // Expected trace of one instruction, from its T0 through its last state.
    task automatic build(input logic [31:0] instr, input int nwait);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        push(mk(5'b11111, 0, 0, M_POUT | M_MAR | M_ZLOEN, 0, 0), "T0", 1'($urandom_range(0, 1)), 0);
        push(mk(0, 0, 0, M_ZLOOUT | M_PEN | M_READ | M_MDREN, 0, 0), "T1", nwait == 0, 0);
        for (int j = 0; j < nwait; j++)
            push(mk(0, 0, 0, M_READ | M_MDREN, 0, 0), "T1W", j == nwait - 1, 0);
        push(mk(0, 0, 0, M_MDROUT | M_IREN, 0, 0), "T2", 1'($urandom_range(0, 1)), 0);
        if (op <= 5'h08) begin
            push(mk(0, 0, sel(rb), M_YEN, 0, 0), "ALU3_T3", 1'($urandom_range(0, 1)), 1);
            push(mk(op, 0, sel(rc), M_ZLOEN, 0, 0), "ALU3_T4", 1'($urandom_range(0, 1)), 1);
            push(mk(0, sel(ra), 0, M_ZLOOUT, 0, 0), "ALU3_T5", 1'($urandom_range(0, 1)), 1);
        end else if (op == 5'h11 || op == 5'h12) begin
            push(mk(op, 0, sel(rb), M_ZLOEN, 0, 0), "UN_T3", 1'($urandom_range(0, 1)), 1);
            push(mk(0, sel(ra), 0, M_ZLOOUT, 0, 0), "UN_T4", 1'($urandom_range(0, 1)), 1);
        end else if (op == 5'h0F || op == 5'h10) begin
            push(mk(0, 0, sel(ra), M_YEN, 0, 0), "MD_T3", 1'($urandom_range(0, 1)), 1);
            push(mk(op, 0, sel(rb), M_ZHIEN | M_ZLOEN, 0, 0), "MD_T4", 1'($urandom_range(0, 1)), 1);
            push(mk(0, 0, 0, M_ZLOOUT | M_LOEN, 0, 0), "MD_T5", 1'($urandom_range(0, 1)), 1);
            push(mk(0, 0, 0, M_ZHIOUT | M_HIEN, 0, 0), "MD_T6", 1'($urandom_range(0, 1)), 1);
        end else if (op == 5'h1B) begin
            push(mk(0, 0, 0, 0, 0, 0), "NOP_T3", 1'($urandom_range(0, 1)), 1);
        end else begin
            push(mk(0, 0, 0, 0, 0, 0), "STOP_T3", 1'($urandom_range(0, 1)), 1);
            for (int j = 0; j < 10; j++)
                push(mk(0, 0, 0, 0, 1, op != 5'h1C), "HALT", 1'($urandom_range(0, 1)), 0);
        end
    endtask

    // Plays the queued trace; ir is garbage outside T3..T6, run toggles freely.
    task automatic play(input logic [31:0] instr, input int limit);
        int n;
        n = (limit < 0) ? q_exp.size() : limit;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ir      = q_real[k] ? instr : $urandom;
            mem_rdy = q_rdy[k];
            run     = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (obs !== q_exp[k]) begin
                n_fail++;
                $display("FAIL %s ir=%h cycle %0d: got %h expected %h", q_name[k], instr, k, obs, q_exp[k]);
            end
        end
        q_exp.delete();
        q_name.delete();
        q_rdy.delete();
        q_real.delete();
    endtask

    task automatic run_instr(input logic [31:0] instr, input int nwait);
        build(instr, nwait);
        play(instr, -1);
    endtask

    task automatic check_idle(input string nm);
        n_checks++;
        if (obs !== 53'd0) begin
            n_fail++;
            $display("FAIL %s: got %h expected 0", nm, obs);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        clr = 1'b0;
        run = 1'b0;
        #1;
        check_idle("reset_async");
        @(negedge clk);
        clr = 1'b1;
        #1;
        check_idle("reset_release");
        @(negedge clk);
        #1;
        check_idle("idle_hold");
    endtask

    task automatic start();
        @(negedge clk);
        run = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr(input int cls);
        logic [4:0] op;
        logic [31:0] lo;
        case (cls)
            0: op = 5'($urandom_range(0, 8));
            1: op = 5'($urandom_range(17, 18));
            2: op = 5'($urandom_range(15, 16));
            3: op = 5'h1B;
            4: op = 5'h1C;
            default: begin
                op = 5'($urandom_range(9, 14));
                case ($urandom_range(0, 2))
                    0: op = 5'($urandom_range(19, 26));
                    1: op = 5'($urandom_range(29, 31));
                    default: ;
                endcase
            end
        endcase
        lo = $urandom;
        return {op, lo[26:0]};
    endfunction

    task automatic test_reset();
        #1;
        check_idle("reset_initial");
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_idle("idle_no_run");
        end
    endtask

    task automatic test_directed();
        start();
        run_instr(32'h00918000, 0);
        run_instr(32'h00918000, 3);
        run_instr(32'h7A280000, 0);
        run_instr(32'h88900000, 1);
        run_instr(32'hD8000000, 0);
        do_reset();
    endtask

    task automatic test_back_to_back();
        start();
        for (int i = 0; i < 40; i++)
            run_instr(rand_instr($urandom_range(0, 3)), $urandom_range(0, 3));
        do_reset();
    endtask

    task automatic test_reset_mid();
        start();
        build(32'h00918000, 0);
        play(32'h00918000, 5);
        do_reset();
        start();
        run_instr(32'h00918000, 0);
        do_reset();
    endtask

    task automatic test_halt_illegal();
        start();
        run_instr(32'hE0000000, 0);
        do_reset();
        start();
        run_instr(32'hF8000000, 2);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            start();
            run_instr(rand_instr(4 + (i % 2)), $urandom_range(0, 2));
            do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_halt_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
